// File: rtl/snake_pkg.sv
// Shared types for the Snake score path: FSM state, BCD digit type and digit limits.
package snake_pkg;

    localparam int unsigned BCD_W = 4;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        CMP  = 2'd1,
        OVER = 2'd2
    } state_t;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder with decimal carry; chained by score_keeper for a ripple add.
module bcd_digit_add
    import snake_pkg::*;
(
    input  bcd_t       a,
    input  logic [3:0] addend,
    input  logic       carry_in,
    output bcd_t       sum,
    output logic       carry_out
);

    logic [4:0] raw;

    always_comb begin
        raw       = 5'(a) + 5'(addend) + 5'(carry_in);
        sum       = raw[3:0];
        carry_out = 1'b0;
        if (raw > 5'(BCD_MAX)) begin
            sum       = 4'(raw - 5'd10);
            carry_out = 1'b1;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Packed-BCD score and session high score for Snake, with a registered digit
// selector feeding display_score.
module score_keeper
    import snake_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned INC    = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  Eat,
    input  logic                  Game_Over,
    input  logic                  New_Game,
    input  logic [1:0]            Sel,
    input  logic                  Show_High,
    output logic [4*DIGITS-1:0]   Score_BCD,
    output logic [4*DIGITS-1:0]   High_BCD,
    output logic [3:0]            Digit_Out,
    output logic                  Playing,
    output logic                  New_High
);

    localparam int unsigned SCORE_W = BCD_W * DIGITS;
    localparam logic [SCORE_W-1:0] SCORE_MAX = {DIGITS{BCD_MAX}};

    state_t               state_q, state_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SCORE_W-1:0]   high_q, high_d;
    logic [SCORE_W-1:0]   score_inc, score_sat;
    logic [DIGITS:0]      carry;
    bcd_t                 digit_q, digit_d;
    logic                 playing_q, playing_d;
    logic                 new_high_q, new_high_d;
    logic                 eat_q;
    logic                 eat_rise;

    assign eat_rise = Eat & ~eat_q;

    // Ripple BCD increment; only the least significant digit receives INC.
    assign carry[0] = 1'b0;
    for (genvar i = 0; i < DIGITS; i++) begin : g_add
        localparam bcd_t ADDEND = (i == 0) ? 4'(INC) : 4'd0;
        bcd_digit_add u_add (
            .a         (score_q[4*i +: 4]),
            .addend    (ADDEND),
            .carry_in  (carry[i]),
            .sum       (score_inc[4*i +: 4]),
            .carry_out (carry[i+1])
        );
    end

    // A carry out of the top digit means overflow: pin at all nines.
    assign score_sat = carry[DIGITS] ? SCORE_MAX : score_inc;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= PLAY;
            score_q    <= '0;
            high_q     <= '0;
            digit_q    <= '0;
            playing_q  <= 1'b1;
            new_high_q <= 1'b0;
            eat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            high_q     <= high_d;
            digit_q    <= digit_d;
            playing_q  <= playing_d;
            new_high_q <= new_high_d;
            eat_q      <= Eat;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PLAY:    if (!New_Game && Game_Over) state_d = CMP;
            CMP:     state_d = OVER;
            OVER:    if (New_Game) state_d = PLAY;
            default: state_d = PLAY;
        endcase
    end

    // New_Game has priority over Game_Over, which in turn swallows a same-cycle eat.
    always_comb begin
        score_d    = score_q;
        high_d     = high_q;
        new_high_d = 1'b0;
        playing_d  = (state_d == PLAY);
        digit_d    = '0;
        case (state_q)
            PLAY: begin
                if (New_Game)                   score_d = '0;
                else if (!Game_Over && eat_rise) score_d = score_sat;
            end
            CMP: begin
                if (score_q > high_q) begin
                    high_d     = score_q;
                    new_high_d = 1'b1;
                end
            end
            OVER: if (New_Game) score_d = '0;
            default: ;
        endcase
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (32'(Sel) == i) digit_d = Show_High ? high_q[4*i +: 4] : score_q[4*i +: 4];
        end
    end

    assign Score_BCD = score_q;
    assign High_BCD  = high_q;
    assign Digit_Out = digit_q;
    assign Playing   = playing_q;
    assign New_High  = new_high_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed plus random bench for score_keeper against a decimal-integer reference model.
module tb_score_keeper;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned INC    = 1;
    localparam int unsigned SW     = 4 * DIGITS;
    localparam int          MAXV   = 9999;
    localparam int          PH_RUN   = 0;
    localparam int          PH_JUDGE = 1;
    localparam int          PH_DEAD  = 2;

    logic          CLK = 1'b0;
    logic          RESET, Eat, Game_Over, New_Game, Show_High;
    logic [1:0]    Sel;
    logic [SW-1:0] Score_BCD, High_BCD;
    logic [3:0]    Digit_Out;
    logic          Playing, New_High;

    int n_err = 0;
    int n_checks = 0;

    int m_score, m_high, m_phase, m_digit;
    bit m_new_high, m_prev_eat, m_playing;

    score_keeper #(.DIGITS(DIGITS), .INC(INC)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .Eat       (Eat),
        .Game_Over (Game_Over),
        .New_Game  (New_Game),
        .Sel       (Sel),
        .Show_High (Show_High),
        .Score_BCD (Score_BCD),
        .High_BCD  (High_BCD),
        .Digit_Out (Digit_Out),
        .Playing   (Playing),
        .New_High  (New_High)
    );

    always #5 CLK = ~CLK;

    function automatic logic [SW-1:0] to_bcd(input int v);
        logic [SW-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int digit_of(input int v, input int pos);
        int x;
        x = v;
        for (int i = 0; i < pos; i++) x = x / 10;
        return x % 10;
    endfunction

    task automatic model_update();
        int d;
        if (RESET) begin
            m_score = 0; m_high = 0; m_digit = 0; m_new_high = 0;
            m_phase = PH_RUN; m_prev_eat = 0;
        end else begin
            d = 0;
            if (int'(Sel) < int'(DIGITS)) d = digit_of(Show_High ? m_high : m_score, int'(Sel));
            m_new_high = 0;
            if (m_phase == PH_RUN) begin
                if (New_Game) m_score = 0;
                else if (Game_Over) m_phase = PH_JUDGE;
                else if (Eat && !m_prev_eat) m_score = (m_score + int'(INC) > MAXV) ? MAXV : m_score + int'(INC);
            end else if (m_phase == PH_JUDGE) begin
                if (m_score > m_high) begin
                    m_high = m_score;
                    m_new_high = 1;
                end
                m_phase = PH_DEAD;
            end else begin
                if (New_Game) begin
                    m_score = 0;
                    m_phase = PH_RUN;
                end
            end
            m_prev_eat = Eat;
            m_digit = d;
        end
        m_playing = (m_phase == PH_RUN);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("score",    32'(Score_BCD), 32'(to_bcd(m_score)));
        check("high",     32'(High_BCD),  32'(to_bcd(m_high)));
        check("digit",    32'(Digit_Out), 32'(m_digit));
        check("playing",  32'(Playing),   32'(m_playing));
        check("new_high", 32'(New_High),  32'(m_new_high));
    endtask

    task automatic tick();
        @(posedge CLK);
        model_update();
        #1;
        check_all();
    endtask

    task automatic eats(input int n);
        repeat (n) begin
            Eat = 1'b1; tick();
            Eat = 1'b0; tick();
        end
    endtask

    task automatic new_game();
        New_Game = 1'b1; tick();
        New_Game = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; Eat = 1'b0; Game_Over = 1'b0; New_Game = 1'b0;
        Sel = 2'd0; Show_High = 1'b0;
        m_score = 0; m_high = 0; m_phase = PH_RUN; m_digit = 0;
        m_new_high = 0; m_prev_eat = 0; m_playing = 1;

        // Reset state
        tick(); tick();
        check("rst_score",   32'(Score_BCD), 32'h0);
        check("rst_high",    32'(High_BCD),  32'h0);
        check("rst_digit",   32'(Digit_Out), 32'h0);
        check("rst_playing", 32'(Playing),   32'h1);
        check("rst_newhigh", 32'(New_High),  32'h0);
        RESET = 1'b0;

        // Held level counts once, then three pulses
        Eat = 1'b1;
        repeat (20) tick();
        Eat = 1'b0; tick();
        eats(3);
        check("t2_score", 32'(Score_BCD), 32'h0004);
        Sel = 2'd0; tick();
        check("t2_digit", 32'(Digit_Out), 32'h4);

        // Decimal carry and saturation
        new_game();
        eats(9);
        check("t3_nine", 32'(Score_BCD), 32'h0009);
        eats(1);
        check("t3_carry", 32'(Score_BCD), 32'h0010);
        new_game();
        eats(9998);
        check("t3_9998", 32'(Score_BCD), 32'h9998);
        eats(1);
        check("t3_9999", 32'(Score_BCD), 32'h9999);
        eats(3);
        check("t3_sat", 32'(Score_BCD), 32'h9999);

        // First game over sets the high score
        new_game();
        eats(42);
        Game_Over = 1'b1; tick();
        check("t4_cmp_playing", 32'(Playing), 32'h0);
        tick();
        check("t4_high", 32'(High_BCD), 32'h0042);
        check("t4_newhigh", 32'(New_High), 32'h1);
        tick();
        check("t4_newhigh_end", 32'(New_High), 32'h0);
        eats(3);
        check("t4_frozen", 32'(Score_BCD), 32'h0042);
        Show_High = 1'b1; Sel = 2'd1; tick();
        check("t4_high_digit", 32'(Digit_Out), 32'h4);
        Show_High = 1'b0; Sel = 2'd0;

        // Equal and lower scores do not replace the high score
        Game_Over = 1'b0;
        new_game();
        check("t5_cleared", 32'(Score_BCD), 32'h0);
        check("t5_playing", 32'(Playing), 32'h1);
        eats(42);
        Game_Over = 1'b1; tick(); tick();
        check("t5_eq_high", 32'(High_BCD), 32'h0042);
        check("t5_eq_newhigh", 32'(New_High), 32'h0);
        Game_Over = 1'b0;
        new_game();
        eats(41);
        Game_Over = 1'b1; tick(); tick();
        check("t5_lo_high", 32'(High_BCD), 32'h0042);
        check("t5_lo_newhigh", 32'(New_High), 32'h0);

        // Eat edge coincident with Game_Over is dropped; reset from OVER
        Game_Over = 1'b0;
        new_game();
        tick();
        Eat = 1'b1; Game_Over = 1'b1; tick();
        check("t6_score", 32'(Score_BCD), 32'h0);
        check("t6_playing", 32'(Playing), 32'h0);
        tick();
        Eat = 1'b0;
        RESET = 1'b1; tick();
        check("t6_rst_high", 32'(High_BCD), 32'h0);
        check("t6_rst_playing", 32'(Playing), 32'h1);
        RESET = 1'b0; Game_Over = 1'b0;

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            RESET     = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 2) == 0) Eat = ~Eat;
            Game_Over = ($urandom_range(0, 79) == 0) ? 1'b1 : (Game_Over && $urandom_range(0, 3) != 0);
            New_Game  = ($urandom_range(0, 49) == 0);
            Sel       = 2'($urandom);
            Show_High = 1'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
